// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw pin level in, debounced level and settling flag out.
interface button_debouncer_if;
    logic btn_in;
    logic level;
    logic settling;

    modport master (
        output btn_in,
        input  level,
        input  settling
    );

    modport slave (
        input  btn_in,
        output level,
        output settling
    );
endinterface

// File: rtl/button_debouncer.sv
// Debounces an asynchronous bouncing button: two-flop synchronizer, four-state
// Moore FSM and a stability counter that must see a new level held long enough.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b10,
        WAIT_LOW  = 2'b11
    } state_e;

    logic             sync1_q, sync1_d;
    logic             btn_s_q, btn_s_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchronizer path: only btn_s_q feeds the FSM.
    always_comb begin
        sync1_d = bus.btn_in;
        btn_s_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            btn_s_q <= btn_s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter: any disagreement while timing aborts back to the held level.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            LOW: begin
                if (btn_s_q) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s_q) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!btn_s_q) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (btn_s_q) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase
    end

    // Outputs decode the state register only, so there is no path from btn_in.
    assign bus.level    = (state_q == HIGH) || (state_q == WAIT_LOW);
    assign bus.settling = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bounce, checked
// against a run-length model of the acceptance rule.
module tb_button_debouncer;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp;
    int   n_bad;

    // Model: two-sample pipeline delay, current accepted level, length of the run
    // of synchronized samples that disagree with it.
    logic m_s1, m_s2, m_lvl, m_settle;
    int   m_run;

    button_debouncer_if bif ();

    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic smp;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_settle = 1'b0;
        end else begin
            smp = m_s2;
            if (smp != m_lvl) begin
                m_run++;
                if (m_run == int'(S) + 1) begin
                    m_lvl = smp;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_settle = (smp != m_lvl);
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic step(input logic b, input logic r);
        @(negedge clk);
        bif.btn_in = b;
        reset      = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check("level",    bif.level,    m_lvl);
        check("settling", bif.settling, m_settle);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // Counts edges from the first sample of b until level follows; expects S+3.
    task automatic latency(input string tag, input logic b);
        int n;
        n = 0;
        do begin
            step(b, 1'b0);
            n++;
        end while (bif.level !== b && n < 50);
        n_cmp++;
        assert (n == int'(S) + 3) else begin
            n_bad++;
            $error("FAIL %s: observed %0d edges expected %0d", tag, n, S + 3);
        end
    endtask

    initial begin
        logic b;
        int   len;
        n_cmp = 0;
        n_bad = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_settle = 1'b0;
        bif.btn_in = 1'b1;
        reset      = 1'b1;

        // Reset with button held, then re-qualification after release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("reset_level", bif.level, 1'b0);
        latency("reset_release_latency", 1'b1);
        hold(1'b1, 4);

        // Clean release, then clean press.
        latency("release_latency", 1'b0);
        hold(1'b0, 6);
        latency("press_latency", 1'b1);
        hold(1'b1, 13);

        // Short glitch while HIGH: level must stay 1.
        hold(1'b0, 3);
        hold(1'b1, 10);
        check("glitch_level_kept", bif.level, 1'b1);

        latency("clean_release_latency", 1'b0);
        hold(1'b0, 6);

        // Bounce on press.
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("bounce_no_rise", bif.level, 1'b0);
        latency("bounce_latency", 1'b1);
        hold(1'b1, 4);

        // Reset in WAIT_HIGH on the completing count.
        latency("release2_latency", 1'b0);
        hold(1'b0, 4);
        hold(1'b1, 6);
        check("midqual_settling", bif.settling, 1'b1);
        step(1'b1, 1'b1);
        check("midqual_reset_level", bif.level, 1'b0);
        latency("midqual_restart_latency", 1'b1);
        hold(1'b1, 4);

        // Random bouncing runs with occasional resets.
        for (int k = 0; k < 200; k++) begin
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++)
                step(b, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
